// File: rtl/idu_exu_reg_if.sv
// Decoded-instruction bundle carried with a valid/ready handshake between pipeline stages.
// The producer uses the master modport; the consumer uses slave and drives ready.
interface idu_exu_reg_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_used;
    logic            rs2_used;
    logic [4:0]      rd;
    logic            r_wen;
    logic            mem_ren;
    logic            mem_wen;
    logic [3:0]      alu_op;

    modport master (
        output valid, pc, src1, src2, imm, rs1, rs2, rs1_used, rs2_used,
               rd, r_wen, mem_ren, mem_wen, alu_op,
        input  ready
    );

    modport slave (
        input  valid, pc, src1, src2, imm, rs1, rs2, rs1_used, rs2_used,
               rd, r_wen, mem_ren, mem_wen, alu_op,
        output ready
    );
endinterface

// File: rtl/idu_exu_reg.sv
// ID/EX pipeline register: handshake capture, load-use bubble insertion, flush clearing,
// valid-gated write enables towards the forwarding arbiter, and a bubble counter.
module idu_exu_reg #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    idu_exu_reg_if.slave     i_idu,
    idu_exu_reg_if.master    o_exu,
    output logic [CNT_W-1:0] o_bubble_cnt
);
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_src1;
    logic [XLEN-1:0] r_src2;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic            r_rs1_used;
    logic            r_rs2_used;
    logic [4:0]      r_rd;
    logic            r_r_wen;
    logic            r_mem_ren;
    logic            r_mem_wen;
    logic [3:0]      r_alu_op;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;
    logic w_idu_ready;
    logic w_accept;

    // A load in EX cannot forward this cycle; a dependent ID instruction must wait one slot.
    assign w_rs1_hit   = i_idu.rs1_used & (i_idu.rs1 == r_rd);
    assign w_rs2_hit   = i_idu.rs2_used & (i_idu.rs2 == r_rd);
    assign w_load_use  = r_valid & r_mem_ren & (r_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);
    assign w_idu_ready = i_flush | ((~r_valid | o_exu.ready) & ~w_load_use);
    assign w_accept    = i_idu.valid & w_idu_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rs1_used   <= 1'b0;
            r_rs2_used   <= 1'b0;
            r_rd         <= '0;
            r_r_wen      <= 1'b0;
            r_mem_ren    <= 1'b0;
            r_mem_wen    <= 1'b0;
            r_alu_op     <= '0;
            r_bubble_cnt <= '0;
        end else if (i_flush) begin
            // Redirect: kill the EX slot and drop the incoming instruction; fields keep old data.
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_pc       <= i_idu.pc;
            r_src1     <= i_idu.src1;
            r_src2     <= i_idu.src2;
            r_imm      <= i_idu.imm;
            r_rs1      <= i_idu.rs1;
            r_rs2      <= i_idu.rs2;
            r_rs1_used <= i_idu.rs1_used;
            r_rs2_used <= i_idu.rs2_used;
            r_rd       <= i_idu.rd;
            r_r_wen    <= i_idu.r_wen;
            r_mem_ren  <= i_idu.mem_ren;
            r_mem_wen  <= i_idu.mem_wen;
            r_alu_op   <= i_idu.alu_op;
        end else if (r_valid && o_exu.ready) begin
            r_valid <= 1'b0;
            if (w_load_use) begin
                r_bubble_cnt <= r_bubble_cnt + CntOne;
            end
        end
    end

    assign i_idu.ready = w_idu_ready;

    assign o_exu.valid    = r_valid;
    assign o_exu.pc       = r_pc;
    assign o_exu.src1     = r_src1;
    assign o_exu.src2     = r_src2;
    assign o_exu.imm      = r_imm;
    assign o_exu.rs1      = r_rs1;
    assign o_exu.rs2      = r_rs2;
    assign o_exu.rs1_used = r_rs1_used;
    assign o_exu.rs2_used = r_rs2_used;
    assign o_exu.rd       = r_rd;
    // Bubbles must never look like a pending write to the forwarding arbiter.
    assign o_exu.r_wen    = r_r_wen & r_valid;
    assign o_exu.mem_ren  = r_mem_ren & r_valid;
    assign o_exu.mem_wen  = r_mem_wen & r_valid;
    assign o_exu.alu_op   = r_alu_op;

    assign o_bubble_cnt = r_bubble_cnt;
endmodule

// File: tb/tb_idu_exu_reg.sv
// Directed bench for idu_exu_reg: scoreboarded captures, load-use stalls, EX back-pressure,
// flush, counter wrap (on a narrow-counter instance) and reset behaviour.
module tb_idu_exu_reg;
    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wen;
        logic        ren;
        logic        mwen;
        logic [3:0]  alu;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        flush4;
    logic [15:0] bubble_cnt;
    logic [3:0]  bubble_cnt4;

    idu_exu_reg_if #(.XLEN(XLEN)) u_idu ();
    idu_exu_reg_if #(.XLEN(XLEN)) u_exu ();
    idu_exu_reg_if #(.XLEN(XLEN)) u_idu4 ();
    idu_exu_reg_if #(.XLEN(XLEN)) u_exu4 ();

    idu_exu_reg #(.XLEN(XLEN), .CNT_W(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .i_idu        (u_idu),
        .o_exu        (u_exu),
        .o_bubble_cnt (bubble_cnt)
    );

    idu_exu_reg #(.XLEN(XLEN), .CNT_W(4)) dut4 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush4),
        .i_idu        (u_idu4),
        .o_exu        (u_exu4),
        .o_bubble_cnt (bubble_cnt4)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    ex_t  q[$];
    ex_t  cur;
    ex_t  last;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ex_t obs_ex();
        ex_t o;
        o.pc   = u_exu.pc;
        o.src1 = u_exu.src1;
        o.src2 = u_exu.src2;
        o.imm  = u_exu.imm;
        o.rd   = u_exu.rd;
        o.wen  = u_exu.r_wen;
        o.ren  = u_exu.mem_ren;
        o.mwen = u_exu.mem_wen;
        o.alu  = u_exu.alu_op;
        return o;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic [4:0] rd, input logic wen, input logic ren,
                         input logic mwen, input logic [3:0] alu);
        u_idu.valid    = v;
        u_idu.pc       = pc;
        u_idu.src1     = pc ^ 32'hA5A5_0000;
        u_idu.src2     = pc + 32'h0000_1000;
        u_idu.imm      = ~pc;
        u_idu.rs1      = rs1;
        u_idu.rs2      = rs2;
        u_idu.rs1_used = u1;
        u_idu.rs2_used = u2;
        u_idu.rd       = rd;
        u_idu.r_wen    = wen;
        u_idu.mem_ren  = ren;
        u_idu.mem_wen  = mwen;
        u_idu.alu_op   = alu;
        cur = '{pc: pc, src1: pc ^ 32'hA5A5_0000, src2: pc + 32'h0000_1000, imm: ~pc,
                rd: rd, wen: wen, ren: ren, mwen: mwen, alu: alu};
    endtask

    // One clock: check IDU_ready before the edge, then EXU_valid and any scoreboard entry after.
    task automatic tick(input logic exp_rdy, input logic exp_acc, input logic exp_vld);
        ex_t e;
        #1;
        chk("idu_ready", 160'(u_idu.ready), 160'(exp_rdy));
        if (exp_acc) q.push_back(cur);
        @(posedge clk);
        #1;
        chk("exu_valid", 160'(u_exu.valid), 160'(exp_vld));
        if (exp_acc && u_exu.valid === 1'b1) begin
            e = q.pop_front();
            last = e;
            chk("ex_fields", 160'(obs_ex()), 160'(e));
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        flush4       = 1'b0;
        u_exu.ready  = 1'b1;
        u_exu4.ready = 1'b1;
        u_idu4.valid = 1'b0;
        u_idu4.pc = '0; u_idu4.src1 = '0; u_idu4.src2 = '0; u_idu4.imm = '0;
        u_idu4.rs1 = 5'd5; u_idu4.rs2 = 5'd0; u_idu4.rs1_used = 1'b1; u_idu4.rs2_used = 1'b0;
        u_idu4.rd = 5'd5; u_idu4.r_wen = 1'b1; u_idu4.mem_ren = 1'b1; u_idu4.mem_wen = 1'b0;
        u_idu4.alu_op = 4'd0;
        last = '0;

        // Reset with a live-looking instruction on the input: nothing may be captured.
        drive(1'b1, 32'hDEAD_0000, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 160'(u_exu.valid), 160'(1'b0));
        chk("rst_fields", 160'(obs_ex()), 160'(ex_t'('0)));
        chk("rst_bubble", 160'(bubble_cnt), 160'(16'd0));
        chk("rst_ready", 160'(u_idu.ready), 160'(1'b1));
        rst_n = 1'b1;

        // addi x1
        drive(1'b1, 32'h0000_0100, 5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 4'd1);
        tick(1'b1, 1'b1, 1'b1);
        chk("addi_rd", 160'(u_exu.rd), 160'(5'd1));
        chk("addi_wen", 160'(u_exu.r_wen), 160'(1'b1));

        // lw x5, then a consumer of x5: one bubble, accepted the cycle after
        drive(1'b1, 32'h0000_0104, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 4'd2);
        tick(1'b1, 1'b1, 1'b1);
        drive(1'b1, 32'h0000_0108, 5'd5, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 4'd3);
        tick(1'b0, 1'b0, 1'b0);
        chk("bubble_1", 160'(bubble_cnt), 160'(16'd1));
        chk("bubble_wen", 160'(u_exu.r_wen), 160'(1'b0));
        chk("bubble_ren", 160'(u_exu.mem_ren), 160'(1'b0));
        chk("bubble_rd_held", 160'(u_exu.rd), 160'(5'd5));
        tick(1'b1, 1'b1, 1'b1);

        // lw x0 followed by a reader of x0: no stall
        drive(1'b1, 32'h0000_010C, 5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 4'd2);
        tick(1'b1, 1'b1, 1'b1);
        drive(1'b1, 32'h0000_0110, 5'd0, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 4'd4);
        tick(1'b1, 1'b1, 1'b1);
        chk("x0_no_bubble", 160'(bubble_cnt), 160'(16'd1));

        // lw x5 followed by an instruction naming rs2=x5 without using it: no stall
        drive(1'b1, 32'h0000_0114, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 4'd2);
        tick(1'b1, 1'b1, 1'b1);
        drive(1'b1, 32'h0000_0118, 5'd3, 5'd5, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 4'd5);
        tick(1'b1, 1'b1, 1'b1);
        chk("rs2_unused_no_bubble", 160'(bubble_cnt), 160'(16'd1));

        // EX back-pressure for 3 cycles while IDU keeps changing its offer
        u_exu.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000_0200 + 32'(i * 4), 5'd5, 5'd4, 1'b1, 1'b1, 5'(20 + i),
                  1'b1, 1'(i), 1'b0, 4'(i));
            tick(1'b0, 1'b0, 1'b1);
            chk("stall_hold", 160'(obs_ex()), 160'(last));
        end
        drive(1'b1, 32'h0000_011C, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 4'd6);
        u_exu.ready = 1'b1;
        tick(1'b1, 1'b1, 1'b1);

        // Flush while a load-use is pending: slot cleared, incoming dropped, no bubble counted
        drive(1'b1, 32'h0000_0120, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 4'd2);
        tick(1'b1, 1'b1, 1'b1);
        flush = 1'b1;
        drive(1'b1, 32'h0000_0124, 5'd6, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 4'd7);
        tick(1'b1, 1'b0, 1'b0);
        chk("flush_wen", 160'(u_exu.r_wen), 160'(1'b0));
        chk("flush_ren", 160'(u_exu.mem_ren), 160'(1'b0));
        chk("flush_pc_held", 160'(u_exu.pc), 160'(32'h0000_0120));
        chk("flush_bubble", 160'(bubble_cnt), 160'(16'd1));
        flush = 1'b0;
        drive(1'b0, 32'h0000_0128, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(1'b1, 1'b0, 1'b0);
        chk("flush_dropped_pc", 160'(u_exu.pc), 160'(32'h0000_0120));

        // Counter wrap on the 4-bit instance: self-dependent loads, one bubble per 2 cycles
        u_idu4.valid = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("cnt4_15", 160'(bubble_cnt4), 160'(4'hF));
        repeat (2) @(posedge clk);
        #1;
        chk("cnt4_wrap", 160'(bubble_cnt4), 160'(4'h0));
        u_idu4.valid = 1'b0;

        // Reset in the middle of an EX stall
        drive(1'b1, 32'h0000_0130, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 4'd8);
        tick(1'b1, 1'b1, 1'b1);
        u_exu.ready = 1'b0;
        drive(1'b1, 32'h0000_0134, 5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1, 1'b1, 4'd9);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst2_valid", 160'(u_exu.valid), 160'(1'b0));
        chk("rst2_fields", 160'(obs_ex()), 160'(ex_t'('0)));
        chk("rst2_bubble", 160'(bubble_cnt), 160'(16'd0));
        chk("rst2_ready", 160'(u_idu.ready), 160'(1'b1));
        chk("sb_empty", 160'(q.size()), 160'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/idu_exu_reg.md
# idu_exu_reg

Pipeline register between decode (IDU) and execute (EXU) in the NPC core. It captures decoded instructions with a valid/ready handshake, detects load-use hazards and inserts one bubble for each, and clears its contents on a redirect flush. It drives the EX-stage destination and write-enable signals into the forwarding arbiter, gating write-enable with valid so that bubbles never forward. It also counts inserted bubbles for performance monitoring.

## Interface
- XLEN, 32, datapath width of pc/src/imm fields
- CNT_W, 16, width of bubble counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  redirect from EXU branch/jump; kills EX slot and incoming ID instruction
- IDU_valid  in  1  IDU presents an instruction
- IDU_ready  out  1  register can accept this cycle
- IDU_pc  in  XLEN  instruction pc
- IDU_src1, IDU_src2  in  XLEN  forwarded operand values
- IDU_imm  in  XLEN  immediate
- IDU_rs1, IDU_rs2  in  5  source register indices
- IDU_rs1_used, IDU_rs2_used  in  1  instruction actually reads rs1/rs2
- IDU_rd  in  5  destination index
- IDU_R_Wen  in  1  writes rd
- IDU_mem_ren, IDU_mem_wen  in  1  load / store
- IDU_alu_op  in  4  ALU opcode
- EXU_valid  out  1  EX slot holds a live instruction
- EXU_ready  in  1  EXU consumes slot this cycle
- EXU_pc, EXU_src1, EXU_src2, EXU_imm  out  XLEN  registered fields
- EXU_rd  out  5  registered rd (to arbiter)
- EXU_R_Wen  out  1  R_Wen_q AND valid_q (to arbiter)
- EXU_mem_ren, EXU_mem_wen  out  1  registered, AND valid_q
- EXU_alu_op  out  4  registered
- bubble_cnt  out  CNT_W  load-use bubbles inserted

## Operation
- State: valid_q, field registers, bubble_cnt.
- load_use = valid_q & mem_ren_q & (rd_q != 0) & ((IDU_rs1_used & IDU_rs1 == rd_q) | (IDU_rs2_used & IDU_rs2 == rd_q)).
- IDU_ready = flush | ((!valid_q | EXU_ready) & !load_use).
- Next-state priority, evaluated each cycle:
  1. !rst_n: valid_q=0, all fields=0, bubble_cnt=0.
  2. flush: valid_q=0; fields are held; the incoming instruction is dropped even though IDU_ready=1.
  3. IDU_valid & IDU_ready: all fields load from IDU_*, valid_q=1.
  4. valid_q & EXU_ready (no accept): valid_q=0. If load_use was also true, bubble_cnt increments.
  5. Otherwise hold.
- Load-use is evaluated only against valid_q. The stalled ID instruction is accepted the cycle after the bubble is inserted, when the load has left EX and the arbiter forwards from WBU.
- bubble_cnt wraps modulo 2^CNT_W. It does not increment on flush cycles.
- When valid_q=0, EXU_R_Wen, EXU_mem_ren and EXU_mem_wen are 0. EXU_rd still shows the held value.
- rd=0 loads never cause a stall.

## Timing
- Latency is 1 cycle, ID accept to EXU_valid.
- Full throughput: back-to-back accepts when EXU_ready stays 1 and there is no load_use.
- IDU_ready is combinational from valid_q, EXU_ready, flush and the IDU rs fields. There is no combinational path from IDU_valid to IDU_ready.
- Every output resets to 0 on the first edge with rst_n=0, including mid-stall and mid-flush. IDU_ready during reset follows its formula over the cleared state.
- Outputs hold stable while valid_q & !EXU_ready, whatever IDU does.
- If flush and load_use are both true, flush wins: no bubble is counted and the slot is cleared.

## Test plan
- Reset, then present addi x1 (rd=1, R_Wen=1) with EXU_ready=1 -> next cycle EXU_valid=1, EXU_rd=1, EXU_R_Wen=1; all outputs 0 while rst_n=0.
- lw x5 in EX, next ID reads rs1=5 used -> IDU_ready=0 one cycle, EXU_valid=0 next cycle, bubble_cnt=1, instruction accepted the following cycle.
- lw x0 in EX, ID reads rs1=0 -> no stall, bubble_cnt stays 0. lw x5 with ID rs2=5 but rs2_used=0 -> no stall.
- EXU_ready=0 for 3 cycles with IDU_valid=1 -> IDU_ready=0 and EX fields unchanged. On release, the new instruction is captured the next edge.
- flush asserted with IDU_valid=1 and a load-use pending -> next cycle EXU_valid=0, EXU_R_Wen=0, bubble_cnt unchanged, dropped instruction never appears.
- Preload bubble_cnt to 0xFFFF via 65535 bubbles (or a forced value), insert one more -> counter reads 0x0000.
